// File: rtl/vc_buffer_bank_pkg.sv
// Shared constants and helpers for the VC buffer bank (widths from global.vh).
package vc_buffer_bank_pkg;
`include "global.vh"

    localparam int NUM_VC = `NUM_VC;
    localparam int VIW    = `VC_INDEX_WIDTH;

    // Indices 6 and 7 are encodable but do not name a real VC.
    function automatic logic vc_ok(input logic [VIW-1:0] vc);
        return (vc < VIW'(NUM_VC));
    endfunction

endpackage

// File: rtl/global.vh
// Shared project-wide widths and counts for the router datapath.
`ifndef GLOBAL_VH
`define GLOBAL_VH
`define TIME_WIDTH     16
`define VC_INDEX_WIDTH 3
`define NUM_VC         6
`endif

// File: rtl/vc_buffer_bank_fifo.sv
// Single-VC FIFO: power-of-two depth, wrapping pointers, combinational head.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state for pointers and occupancy; push and pop together keep count.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flit storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == CW'(0));
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/vc_buffer_bank.sv
// Six-VC input buffer bank with input/output steering and registered dequeue.
// Optional same-cycle bypass of empty VCs is enabled by defining VCBUF_BYPASS_EN.
`include "global.vh"

module vc_buffer_bank
    import vc_buffer_bank_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [`VC_INDEX_WIDTH-1:0] in_vc,
    input  logic [`TIME_WIDTH-1:0]     in_time,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic [`TIME_WIDTH-1:0]     time_out_0,
    output logic [`TIME_WIDTH-1:0]     time_out_1,
    output logic [`TIME_WIDTH-1:0]     time_out_2,
    output logic [`TIME_WIDTH-1:0]     time_out_3,
    output logic [`TIME_WIDTH-1:0]     time_out_4,
    output logic [`TIME_WIDTH-1:0]     time_out_5,
    output logic [NUM_VC-1:0]          vc_valid,
    input  logic                       deq_en,
    input  logic [`VC_INDEX_WIDTH-1:0] deq_vc,
    output logic                       out_valid,
    output logic [`TIME_WIDTH-1:0]     out_time,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [NUM_VC-1:0]          credit_out,
    output logic [NUM_VC-1:0]          full,
    output logic                       err
);
    localparam int TW = `TIME_WIDTH;
    localparam int FW = TW + DATA_WIDTH;

    logic [FW-1:0]     head_s [NUM_VC];
    logic [TW-1:0]     time_s [NUM_VC];
    logic [NUM_VC-1:0] empty_s, full_s, push_s, pop_s, byp_s, in_hit_s;
    logic              err_set_s;
    logic [FW-1:0]     out_sel_s;

    logic              out_valid_q, out_valid_d;
    logic [TW-1:0]     out_time_q, out_time_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_VC-1:0] credit_q, credit_d;
    logic              err_q, err_d;

    for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
        vc_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_s[k]),
            .pop   (pop_s[k]),
            .wdata ({in_time, in_data}),
            .head  (head_s[k]),
            .empty (empty_s[k]),
            .full  (full_s[k])
        );
`ifdef VCBUF_BYPASS_EN
        assign time_s[k]   = !empty_s[k] ? head_s[k][FW-1:DATA_WIDTH] :
                             (in_hit_s[k] ? in_time : {TW{1'b1}});
        assign vc_valid[k] = !empty_s[k] || in_hit_s[k];
`else
        assign time_s[k]   = !empty_s[k] ? head_s[k][FW-1:DATA_WIDTH] : {TW{1'b1}};
        assign vc_valid[k] = !empty_s[k];
`endif
    end

    // Steer enqueue/dequeue strobes to the FIFOs and collect error causes.
    always_comb begin
        push_s    = '0;
        pop_s     = '0;
        byp_s     = '0;
        in_hit_s  = '0;
        out_sel_s = '0;
        err_set_s = (in_valid && !vc_ok(in_vc)) || (deq_en && !vc_ok(deq_vc));
        for (int k = 0; k < NUM_VC; k++) begin
            in_hit_s[k] = in_valid && (in_vc == VIW'(k));
`ifdef VCBUF_BYPASS_EN
            byp_s[k] = in_hit_s[k] && deq_en && (deq_vc == VIW'(k)) && empty_s[k];
`else
            byp_s[k] = 1'b0;
`endif
            pop_s[k]  = deq_en && (deq_vc == VIW'(k)) && !empty_s[k];
            push_s[k] = in_hit_s[k] && (!full_s[k] || pop_s[k]) && !byp_s[k];
            if (in_hit_s[k] && full_s[k] && !pop_s[k]) begin
                err_set_s = 1'b1;
            end else if (deq_en && (deq_vc == VIW'(k)) && empty_s[k] && !byp_s[k]) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = err_set_s;
            end
            if (pop_s[k]) begin
                out_sel_s = head_s[k];
            end else begin
                out_sel_s = out_sel_s;
            end
        end
    end

    // Next state of the registered dequeue port, credits and sticky error.
    always_comb begin
        out_valid_d = (|pop_s) || (|byp_s);
        credit_d    = pop_s | byp_s;
        err_d       = err_q || err_set_s;
        out_time_d  = out_time_q;
        out_data_d  = out_data_q;
        if (|byp_s) begin
            out_time_d = in_time;
            out_data_d = in_data;
        end else if (|pop_s) begin
            out_time_d = out_sel_s[FW-1:DATA_WIDTH];
            out_data_d = out_sel_s[DATA_WIDTH-1:0];
        end else begin
            out_time_d = out_time_q;
            out_data_d = out_data_q;
        end
    end

    // Output and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_time_q  <= '0;
            out_data_q  <= '0;
            credit_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_time_q  <= out_time_d;
            out_data_q  <= out_data_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
        end
    end

    assign time_out_0 = time_s[0];
    assign time_out_1 = time_s[1];
    assign time_out_2 = time_s[2];
    assign time_out_3 = time_s[3];
    assign time_out_4 = time_s[4];
    assign time_out_5 = time_s[5];
    assign full       = full_s;
    assign out_valid  = out_valid_q;
    assign out_time   = out_time_q;
    assign out_data   = out_data_q;
    assign credit_out = credit_q;
    assign err        = err_q;

endmodule
